sample_expand: RTL and testbench
================================

SAMPLE_EXPAND -- requirements
Module: sample_expand

Interface
REQ-001 SHALL have parameter IN_W, default 8, signed input sample width.
REQ-002 SHALL have parameter OUT_W, default 16, signed output sample width; OUT_W >= IN_W.
REQ-003 SHALL have parameter SHIFT_W, default 4, width of shift exponent (range 0..2^SHIFT_W-1).
REQ-004 SHALL have parameter FRAME_LEN, default 64, samples per frame, >= 2.
REQ-005 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-006 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port s_valid  input  1  input sample valid.
REQ-008 SHALL have port s_ready  output  1  block accepts input this cycle.
REQ-009 SHALL have port s_data  input  IN_W  signed narrow sample.
REQ-010 SHALL have port s_shift  input  SHIFT_W  left-shift exponent, sampled at frame start only.
REQ-011 SHALL have port m_valid  output  1  output sample valid.
REQ-012 SHALL have port m_ready  input  1  downstream accepts output.
REQ-013 SHALL have port m_data  output  OUT_W  signed expanded sample.
REQ-014 SHALL have port m_sat  output  1  m_data was clipped.
REQ-015 SHALL have port m_last  output  1  m_data is last sample of frame.
REQ-016 SHALL have port frame_sat  output  1  sticky: any sample of current/just-finished frame clipped.

Function
REQ-017 SHALL transfer input when s_valid && s_ready; output when m_valid && m_ready.
REQ-018 SHALL drive s_ready = !m_valid || m_ready (single output register, no combinational path s_valid->m_valid).
REQ-019 SHALL register accepted sample to m_data/m_valid on the next rising edge: latency 1 cycle.
REQ-020 SHALL hold m_data, m_sat, m_last, m_valid stable while m_valid && !m_ready.
REQ-021 SHALL clear m_valid on an edge where output transfers and no input transfers.
REQ-022 SHALL compute result = sign-extend(s_data) arithmetically shifted left by latched shift, in IN_W+2^SHIFT_W-1 bit intermediate, no truncation.
REQ-023 SHALL saturate result to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set m_sat=1 for that sample when clipped; else m_sat=0.
REQ-024 SHALL use two states: IDLE (no frame open) and RUN (frame in progress).
REQ-025 SHALL, in IDLE, on input transfer: latch s_shift as frame exponent, use it for this sample, set sample count to 1, go to RUN.
REQ-026 SHALL, in RUN, ignore s_shift; each input transfer uses latched exponent and increments count.
REQ-027 SHALL set m_last with the sample for which count reaches FRAME_LEN, reset count to 0, return to IDLE.
REQ-028 SHALL clear frame_sat on the first input transfer of a frame (then OR in that sample's sat), set it on any clipped sample, hold it after frame end until the next frame's first transfer.
REQ-029 SHALL allow back-to-back frames with no idle cycle: sample after last is first of new frame with fresh exponent.
REQ-030 SHALL treat zero input as never saturating, for any exponent.

Reset
REQ-031 SHALL, with rst_n=0 at a rising edge, set m_valid=0, m_data=0, m_sat=0, m_last=0, frame_sat=0, count=0, exponent=0, state IDLE.
REQ-032 SHALL drive s_ready=1 during and after reset (m_valid=0).
REQ-033 SHALL discard any partial frame on reset mid-frame; first transfer after reset starts a new frame.

Verification
REQ-034 SHALL verify: shift=0, s_data=-128 -> m_data=0xFF80 one cycle later, m_sat=0.
REQ-035 SHALL verify: shift=4, s_data=127 then -1 -> m_data=0x07F0 then 0xFFF0, m_sat=0.
REQ-036 SHALL verify: shift=9, s_data=127 -> 0x7FFF, m_sat=1; s_data=-128 -> 0x8000, m_sat=1; s_data=0 -> 0x0000, m_sat=0; frame_sat=1 after first clip.
REQ-037 SHALL verify: m_ready=0 for 3 cycles with s_valid=1 -> m_data held, s_ready=0, no sample lost or duplicated after m_ready=1.
REQ-038 SHALL verify: FRAME_LEN=4, s_shift changed 2->5 on sample 2 -> samples 1-4 use shift 2, m_last on sample 4, sample 5 uses shift 5 with no gap.
REQ-039 SHALL verify: rst_n=0 after 2 of 4 samples -> all outputs 0, next frame's m_last on its 4th sample.

Source files
------------

// File: rtl/sample_expand.sv
// Widens signed samples by a per-frame left-shift exponent, saturating to OUT_W.
// A single output register with valid/ready on both sides; frame_sat tracks clipping per frame.
module sample_expand #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 16,
  parameter int SHIFT_W   = 4,
  parameter int FRAME_LEN = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [IN_W-1:0]    s_data,
  input  logic [SHIFT_W-1:0] s_shift,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_data,
  output logic               m_sat,
  output logic               m_last,
  output logic               frame_sat,
  output logic               dbg_state
);

  // Handshake: a beat moves on a rising edge where valid && ready on that side.
  // s_ready depends only on the output register and m_ready, never on s_valid.

  localparam int INT_W = IN_W + (2 ** SHIFT_W) - 1;
  localparam int CMP_W = ((INT_W > OUT_W) ? INT_W : OUT_W) + 1;
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic signed [CMP_W-1:0] SAT_MAX =
    {{(CMP_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [CMP_W-1:0] SAT_MIN =
    {{(CMP_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q;
  logic [CNT_W-1:0]     count_q;
  logic [SHIFT_W-1:0]   exp_q;
  logic                 m_valid_q;
  logic [OUT_W-1:0]     m_data_q;
  logic                 m_sat_q;
  logic                 m_last_q;
  logic                 frame_sat_q;

  logic                 in_xfer;
  logic [SHIFT_W-1:0]   shift_use;
  logic signed [CMP_W-1:0] ext;
  logic signed [CMP_W-1:0] shifted;
  logic                 sat_hi;
  logic                 sat_lo;
  logic [OUT_W-1:0]     data_d;
  logic                 sat_d;
  logic                 last_d;

  assign s_ready   = !m_valid_q || m_ready;
  assign in_xfer   = s_valid && s_ready;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_sat     = m_sat_q;
  assign m_last    = m_last_q;
  assign frame_sat = frame_sat_q;
  assign dbg_state = state_q;

  // The first sample of a frame uses the live exponent; later ones use the latched copy.
  // The comparison width leaves headroom so the shift never loses bits before clipping.
  always_comb begin
    shift_use = (state_q == IDLE) ? s_shift : exp_q;
    ext       = {{(CMP_W - IN_W){s_data[IN_W-1]}}, s_data};
    shifted   = ext << shift_use;
    sat_hi    = shifted > SAT_MAX;
    sat_lo    = shifted < SAT_MIN;
    sat_d     = sat_hi || sat_lo;
    if (sat_hi) begin
      data_d = SAT_MAX[OUT_W-1:0];
    end else if (sat_lo) begin
      data_d = SAT_MIN[OUT_W-1:0];
    end else begin
      data_d = shifted[OUT_W-1:0];
    end
    last_d = (state_q == RUN) && (count_q == LAST_CNT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      exp_q       <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_sat_q     <= 1'b0;
      m_last_q    <= 1'b0;
      frame_sat_q <= 1'b0;
    end else begin
      if (in_xfer) begin
        m_valid_q <= 1'b1;
        m_data_q  <= data_d;
        m_sat_q   <= sat_d;
        m_last_q  <= last_d;
        case (state_q)
          IDLE: begin
            exp_q       <= s_shift;
            count_q     <= CNT_W'(1);
            state_q     <= RUN;
            frame_sat_q <= sat_d;
          end
          RUN: begin
            frame_sat_q <= frame_sat_q || sat_d;
            if (last_d) begin
              count_q <= '0;
              state_q <= IDLE;
            end else begin
              count_q <= count_q + CNT_W'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sample_expand.sv
// Directed bench for sample_expand with FRAME_LEN=4: vector table plus
// hand-written backpressure and mid-frame reset sequences.
module tb_sample_expand;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic [3:0]  s_shift;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_sat;
  logic        m_last;
  logic        frame_sat;
  logic        dbg_state;

  int tests = 0;
  int fails = 0;

  sample_expand #(
    .IN_W(8), .OUT_W(16), .SHIFT_W(4), .FRAME_LEN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_shift(s_shift),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sat(m_sat), .m_last(m_last), .frame_sat(frame_sat),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // driver: present one sample, let it register, compare {valid,sat,last,frame_sat,data}
  task automatic send_chk(input string name, input logic [3:0] shift, input logic [7:0] data,
                          input logic [15:0] exp_data, input logic exp_sat,
                          input logic exp_last, input logic exp_fsat);
    s_valid = 1'b1;
    s_data  = data;
    s_shift = shift;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk(name, {12'd0, m_valid, m_sat, m_last, frame_sat, m_data},
        {12'd0, 1'b1, exp_sat, exp_last, exp_fsat, exp_data});
  endtask

  // scoreboard: {last, data} of every output transfer, checked on the falling edge
  logic [16:0] exp_q[$];
  logic        mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_extra", {15'd0, m_last, m_data}, 32'h1ffff);
      end else begin
        chk("sb_data", {15'd0, m_last, m_data}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  typedef struct {
    logic [3:0]  shift;
    logic [7:0]  data;
    logic [15:0] exp_data;
    logic        exp_sat;
    logic        exp_last;
    logic        exp_fsat;
  } vec_t;

  vec_t vecs[28];

  initial begin
    // frame A: shift 0
    vecs[0]  = '{4'd0,  8'h80, 16'hFF80, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'd7,  8'h7F, 16'h007F, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'd7,  8'hFF, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{4'd7,  8'h00, 16'h0000, 1'b0, 1'b1, 1'b0};
    // frame B: shift 4, later shift values must be ignored
    vecs[4]  = '{4'd4,  8'h7F, 16'h07F0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'd9,  8'hFF, 16'hFFF0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'd9,  8'h80, 16'hF800, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'd9,  8'h01, 16'h0010, 1'b0, 1'b1, 1'b0};
    // frame C: shift 9, clipping both ways, -64<<9 is exactly the minimum
    vecs[8]  = '{4'd9,  8'h7F, 16'h7FFF, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{4'd0,  8'h80, 16'h8000, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{4'd0,  8'h00, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{4'd0,  8'hC0, 16'h8000, 1'b0, 1'b1, 1'b1};
    // frame D: shift 15
    vecs[12] = '{4'd15, 8'h01, 16'h7FFF, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{4'd2,  8'hFF, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{4'd2,  8'h00, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{4'd2,  8'hFE, 16'h8000, 1'b1, 1'b1, 1'b1};
    // frame E: shift 8, frame_sat cleared by the first sample
    vecs[16] = '{4'd8,  8'h7F, 16'h7F00, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{4'd15, 8'h80, 16'h8000, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{4'd15, 8'h01, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{4'd15, 8'h00, 16'h0000, 1'b0, 1'b1, 1'b0};
    // frame F: shift 2, s_shift moves to 5 from sample 2
    vecs[20] = '{4'd2,  8'h03, 16'h000C, 1'b0, 1'b0, 1'b0};
    vecs[21] = '{4'd5,  8'h03, 16'h000C, 1'b0, 1'b0, 1'b0};
    vecs[22] = '{4'd5,  8'h03, 16'h000C, 1'b0, 1'b0, 1'b0};
    vecs[23] = '{4'd5,  8'h03, 16'h000C, 1'b0, 1'b1, 1'b0};
    // frame G: starts back-to-back with shift 5
    vecs[24] = '{4'd5,  8'h03, 16'h0060, 1'b0, 1'b0, 1'b0};
    vecs[25] = '{4'd0,  8'h01, 16'h0020, 1'b0, 1'b0, 1'b0};
    vecs[26] = '{4'd0,  8'h01, 16'h0020, 1'b0, 1'b0, 1'b0};
    vecs[27] = '{4'd0,  8'h01, 16'h0020, 1'b0, 1'b1, 1'b0};

    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_shift = 4'd0;
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {26'd0, m_valid, m_sat, m_last, frame_sat, dbg_state, s_ready},
        32'h0000_0001);
    chk("reset_data", {16'd0, m_data}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      send_chk($sformatf("vec%0d", i), vecs[i].shift, vecs[i].data, vecs[i].exp_data,
               vecs[i].exp_sat, vecs[i].exp_last, vecs[i].exp_fsat);
    end
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("drain_valid", {31'd0, m_valid}, 32'd0);
    chk("idle_state", {31'd0, dbg_state}, 32'd0);

    // backpressure: hold m_ready low 3 cycles with s_valid high
    exp_q.push_back({1'b0, 16'h0005});
    exp_q.push_back({1'b0, 16'h0006});
    exp_q.push_back({1'b0, 16'h0007});
    exp_q.push_back({1'b1, 16'h0008});
    mon_en  = 1'b1;
    s_valid = 1'b1;
    s_shift = 4'd0;
    s_data  = 8'd5;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    s_data  = 8'd6;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("stall_data%0d", c), {15'd0, m_valid, m_data}, {15'd0, 1'b1, 16'h0005});
      chk($sformatf("stall_ready%0d", c), {31'd0, s_ready}, 32'd0);
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release", {16'd0, m_data}, 32'h0006);
    s_data = 8'd7;
    @(posedge clk);
    #1;
    s_data = 8'd8;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk("sb_lost", exp_q.size(), 32'd0);
    chk("sb_valid_clear", {31'd0, m_valid}, 32'd0);

    // reset after 2 of 4 samples discards the partial frame
    send_chk("part0", 4'd1, 8'd1, 16'h0002, 1'b0, 1'b0, 1'b0);
    send_chk("part1", 4'd1, 8'd2, 16'h0004, 1'b0, 1'b0, 1'b0);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    @(posedge clk);
    #1;
    chk("midreset_outputs", {26'd0, m_valid, m_sat, m_last, frame_sat, dbg_state, s_ready},
        32'h0000_0001);
    chk("midreset_data", {16'd0, m_data}, 32'h0);
    rst_n = 1'b1;
    send_chk("post0", 4'd3, 8'd1, 16'h0008, 1'b0, 1'b0, 1'b0);
    send_chk("post1", 4'd0, 8'd1, 16'h0008, 1'b0, 1'b0, 1'b0);
    send_chk("post2", 4'd0, 8'd1, 16'h0008, 1'b0, 1'b0, 1'b0);
    send_chk("post3", 4'd0, 8'd1, 16'h0008, 1'b0, 1'b1, 1'b0);
    s_valid = 1'b0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
